// File: rtl/seg7_pkg.sv
// Shared types and the hex-to-segment table for the seven-segment scan controller.
// Segment vectors are ordered gfedcba and active-low.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b111_1111;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        ON
    } scan_state_t;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b100_0000;
            4'h1: seg = 7'b111_1001;
            4'h2: seg = 7'b010_0100;
            4'h3: seg = 7'b011_0000;
            4'h4: seg = 7'b001_1001;
            4'h5: seg = 7'b001_0010;
            4'h6: seg = 7'b000_0010;
            4'h7: seg = 7'b111_1000;
            4'h8: seg = 7'b000_0000;
            4'h9: seg = 7'b001_0000;
            4'hA: seg = 7'b000_1000;
            4'hB: seg = 7'b000_0011;
            4'hC: seg = 7'b100_0110;
            4'hD: seg = 7'b010_0001;
            4'hE: seg = 7'b000_0110;
            default: seg = 7'b000_1110;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low gfedcba segment decoder.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = hex_to_seg(hex);
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed common-anode seven-segment scan controller with a blanking
// guard at the start of every digit slot and frame-aligned display updates.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    output logic                    load_ack,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic [6:0]              seg_out,
    output logic                    dp_out
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CW-1:0]         SLOT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0]         BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0]         DIGIT_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_ONE     = NUM_DIGITS'(1);

    scan_state_t                  state;
    logic [CW-1:0]                slot_cnt;
    logic [IW-1:0]                digit_idx;

    logic [NUM_DIGITS-1:0][3:0]   disp_data;
    logic [NUM_DIGITS-1:0]        disp_dp;
    logic [NUM_DIGITS-1:0]        disp_blank;
    logic [NUM_DIGITS-1:0][3:0]   pend_data;
    logic [NUM_DIGITS-1:0]        pend_dp;
    logic [NUM_DIGITS-1:0]        pend_blank;
    logic                         pend_valid;

    logic                         frame_wrap;
    logic                         commit;
    logic [3:0]                   cur_nib;
    logic [6:0]                   dec_seg;

    always_comb begin
        frame_wrap = (state == ON) && (slot_cnt == SLOT_LAST) && (digit_idx == DIGIT_LAST);
        // While scanning, the display register may only change on the wrap that
        // starts a new frame, so every digit of a frame shows the same value.
        commit     = pend_valid && ((state == IDLE) || (enable && frame_wrap));
        cur_nib    = disp_data[digit_idx];
    end

    hex_to_seg7 u_dec (
        .hex (cur_nib),
        .seg (dec_seg)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            slot_cnt  <= '0;
            digit_idx <= '0;
            an_out    <= '1;
            seg_out   <= SEG_BLANK;
            dp_out    <= 1'b1;
        end else begin
            if (!enable) begin
                state     <= IDLE;
                slot_cnt  <= '0;
                digit_idx <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state     <= BLANK;
                        slot_cnt  <= '0;
                        digit_idx <= '0;
                    end
                    BLANK: begin
                        slot_cnt <= slot_cnt + 1'b1;
                        if (slot_cnt == BLANK_LAST) state <= ON;
                    end
                    ON: begin
                        if (slot_cnt == SLOT_LAST) begin
                            slot_cnt  <= '0;
                            state     <= BLANK;
                            digit_idx <= (digit_idx == DIGIT_LAST) ? '0 : digit_idx + 1'b1;
                        end else begin
                            slot_cnt <= slot_cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end

            // Outputs follow the scan position of the current cycle, one cycle late.
            an_out  <= (state == ON) ? ~(AN_ONE << digit_idx) : '1;
            seg_out <= ((state == IDLE) || disp_blank[digit_idx]) ? SEG_BLANK : dec_seg;
            dp_out  <= ~((state != IDLE) && !disp_blank[digit_idx] && disp_dp[digit_idx]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_data  <= '0;
            disp_dp    <= '0;
            disp_blank <= '0;
            pend_data  <= '0;
            pend_dp    <= '0;
            pend_blank <= '0;
            pend_valid <= 1'b0;
            load_ack   <= 1'b0;
        end else begin
            load_ack <= commit;
            if (commit) begin
                disp_data  <= pend_data;
                disp_dp    <= pend_dp;
                disp_blank <= pend_blank;
            end
            // A load in the commit cycle refills pending rather than being dropped.
            if (load) begin
                pend_data  <= data_in;
                pend_dp    <= dp_in;
                pend_blank <= blank_in;
                pend_valid <= 1'b1;
            end else if (commit) begin
                pend_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
module tb_seg7_scan_ctrl;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        load;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic        load_ack;
    logic [3:0]  an_out;
    logic [6:0]  seg_out;
    logic        dp_out;

    int total = 0;
    int bad   = 0;
    int k     = 0;
    int commit_k = -1;

    logic [6:0] cur_seg [4];
    logic       cur_dp  [4];
    logic [6:0] nxt_seg [4];
    logic       nxt_dp  [4];

    seg7_scan_ctrl #(
        .NUM_DIGITS   (4),
        .REFRESH_DIV  (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .load     (load),
        .data_in  (data_in),
        .dp_in    (dp_in),
        .blank_in (blank_in),
        .load_ack (load_ack),
        .an_out   (an_out),
        .seg_out  (seg_out),
        .dp_out   (dp_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s k=%0d: got %h want %h", tag, k, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_dark(input string tag);
        chk({tag, "_an"}, {4'h0, an_out}, 8'h0F);
        chk({tag, "_seg"}, {1'b0, seg_out}, 8'h7F);
        chk({tag, "_dp"}, {7'h0, dp_out}, 8'h01);
    endtask

    // k counts edges since the scan was enabled from IDLE; output at edge k shows scan position k-2.
    task automatic run(input int n);
        int p, d, s;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_dp;
        for (int i = 0; i < n; i++) begin
            tick();
            k++;
            if (k == commit_k + 1) begin
                cur_seg = nxt_seg;
                cur_dp  = nxt_dp;
            end
            exp_an  = 4'hF;
            exp_seg = 7'h7F;
            exp_dp  = 1'b1;
            if (k >= 2) begin
                p = k - 2;
                d = (p / 8) % 4;
                s = p % 8;
                if (s >= 2) exp_an[d] = 1'b0;
                exp_seg = cur_seg[d];
                exp_dp  = cur_dp[d];
            end
            chk("an", {4'h0, an_out}, {4'h0, exp_an});
            chk("seg", {1'b0, seg_out}, {1'b0, exp_seg});
            chk("dp", {7'h0, dp_out}, {7'h0, exp_dp});
            chk("ack", {7'h0, load_ack}, {7'h0, (k == commit_k)});
        end
    endtask

    initial begin
        rst      = 1'b1;
        enable   = 1'b0;
        load     = 1'b0;
        data_in  = '0;
        dp_in    = '0;
        blank_in = '0;
        for (int i = 0; i < 4; i++) begin
            cur_seg[i] = 7'h40;
            cur_dp[i]  = 1'b1;
        end
        nxt_seg = cur_seg;
        nxt_dp  = cur_dp;

        // Reset values
        tick();
        tick();
        chk_dark("rst");
        chk("rst_ack", {7'h0, load_ack}, 8'h00);
        rst = 1'b0;
        tick();
        chk_dark("idle");

        // Blank scan of all-zero display
        enable = 1'b1;
        k = 0;
        run(36);

        // Drop enable while digit0 is ON
        enable = 1'b0;
        tick();
        chk("drop_an1", {4'h0, an_out}, 8'h0E);
        tick();
        chk_dark("drop2");

        // Load while idle: commit and ack one cycle after capture
        load    = 1'b1;
        data_in = 16'h81C0;
        dp_in   = 4'b0010;
        tick();
        load = 1'b0;
        chk("idle_ack0", {7'h0, load_ack}, 8'h00);
        tick();
        chk("idle_ack1", {7'h0, load_ack}, 8'h01);
        tick();
        chk("idle_ack2", {7'h0, load_ack}, 8'h00);
        chk_dark("idle_load");

        cur_seg[0] = 7'h40; cur_dp[0] = 1'b1;
        cur_seg[1] = 7'h46; cur_dp[1] = 1'b0;
        cur_seg[2] = 7'h79; cur_dp[2] = 1'b1;
        cur_seg[3] = 7'h00; cur_dp[3] = 1'b1;
        nxt_seg = cur_seg;
        nxt_dp  = cur_dp;
        enable = 1'b1;
        k = 0;
        run(42);

        // Two loads during digit1: latest wins, single ack at frame boundary
        load    = 1'b1;
        data_in = 16'h1111;
        dp_in   = 4'b0000;
        run(1);
        load = 1'b0;
        run(2);
        load    = 1'b1;
        data_in = 16'h2222;
        run(1);
        load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            nxt_seg[i] = 7'h24;
            nxt_dp[i]  = 1'b1;
        end
        commit_k = 65;
        run(52);

        // Blank digit2
        load     = 1'b1;
        blank_in = 4'b0100;
        nxt_seg[2] = 7'h7F;
        commit_k = 129;
        run(1);
        load = 1'b0;
        run(64);

        // Asynchronous reset mid-slot discards pending load
        load    = 1'b1;
        data_in = 16'hFFFF;
        run(1);
        load = 1'b0;
        #2 rst = 1'b1;
        #1 chk_dark("async_rst");
        @(negedge clk);
        chk_dark("rst_held");
        chk("rst_held_ack", {7'h0, load_ack}, 8'h00);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cur_seg[i] = 7'h40;
            cur_dp[i]  = 1'b1;
        end
        nxt_seg  = cur_seg;
        nxt_dp   = cur_dp;
        commit_k = -1;
        k = 0;
        run(34);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
